// File: rtl/vx_mem_line_serializer_pkg.sv
// Shared types and sizing for the Vortex line-to-word memory serializer.
// Line geometry is fixed here so the interface and the datapath agree on widths.
package vx_mem_serializer_pkg;

  localparam int LINE_BYTES = 64;
  localparam int WORDS      = LINE_BYTES / 4;
  localparam int WORD_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LINE_SHIFT = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} ser_state_t;

  // Byte address of word idx within a line; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] line_addr,
                                            input logic [31:0] idx);
    return base + (line_addr << LINE_SHIFT) + (idx << 2);
  endfunction

endpackage

// File: rtl/vx_mem_line_serializer_if.sv
// Bundles the Vortex line-wide memory port and the 32-bit word bus.
// master = the serializer (it masters the word bus); slave = Vortex plus bus target.
interface vx_mem_line_serializer_if
  import vx_mem_serializer_pkg::*;
#(
  parameter int ADDR_W = 26,
  parameter int TAG_W  = 8
);

  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [LINE_BYTES-1:0]   mem_req_byteen;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic [LINE_BYTES*8-1:0] mem_req_data;
  logic [TAG_W-1:0]        mem_req_tag;
  logic                    mem_req_ready;

  logic                    mem_rsp_valid;
  logic [LINE_BYTES*8-1:0] mem_rsp_data;
  logic [TAG_W-1:0]        mem_rsp_tag;
  logic                    mem_rsp_ready;

  logic                    busy;

  logic [31:0]             bus_addr;
  logic                    bus_ren;
  logic                    bus_wen;
  logic [31:0]             bus_wdata;
  logic [3:0]              bus_strobe;
  logic [31:0]             bus_rdata;
  logic                    bus_request_stall;

  modport master (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data,
           mem_req_tag, mem_rsp_ready, bus_rdata, bus_request_stall,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag, busy,
           bus_addr, bus_ren, bus_wen, bus_wdata, bus_strobe
  );

  modport slave (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data,
           mem_req_tag, mem_rsp_ready, bus_rdata, bus_request_stall,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag, busy,
           bus_addr, bus_ren, bus_wen, bus_wdata, bus_strobe
  );

endinterface

// File: rtl/vx_mem_line_serializer.sv
// Serializes one Vortex line request into 32-bit word bus accesses; reads are
// gathered back into a line and returned with their tag, writes skip empty words.
module vx_mem_line_serializer
  import vx_mem_serializer_pkg::*;
#(
  parameter int          ADDR_W    = 26,
  parameter int          TAG_W     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_mem_line_serializer_if.master sif
);

  ser_state_t              state_q, state_d;
  logic                    rw_q, rw_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [LINE_BYTES-1:0]   byteen_q, byteen_d;
  logic [WORD_IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]             line_q [WORDS];
  logic [31:0]             line_d [WORDS];
  logic [3:0]              cur_be;
  logic                    last_word;
  logic                    word_done;

  assign cur_be    = byteen_q[{idx_q, 2'b00} +: 4];
  assign last_word = (idx_q == WORD_IDX_W'(WORDS - 1));

  // The line buffer holds write data on the way out and read data on the way back.
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    byteen_d  = byteen_q;
    idx_d     = idx_q;
    line_d    = line_q;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (sif.mem_req_valid) begin
          rw_d     = sif.mem_req_rw;
          addr_d   = sif.mem_req_addr;
          tag_d    = sif.mem_req_tag;
          byteen_d = sif.mem_req_byteen;
          for (int w = 0; w < WORDS; w++) line_d[w] = sif.mem_req_data[32*w +: 32];
          idx_d    = '0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (!rw_q) begin
          if (!sif.bus_request_stall) begin
            line_d[idx_q] = sif.bus_rdata;
            word_done     = 1'b1;
          end
        end else if (cur_be == 4'h0 || !sif.bus_request_stall) begin
          word_done = 1'b1;
        end
        if (word_done) begin
          idx_d = idx_q + 1'b1;
          if (last_word) state_d = rw_q ? IDLE : RESP;
        end
      end
      RESP: begin
        if (sif.mem_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      tag_q    <= '0;
      byteen_q <= '0;
      idx_q    <= '0;
      line_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      byteen_q <= byteen_d;
      idx_q    <= idx_d;
      line_q   <= line_d;
    end
  end

  // Outputs decode only registered state, so the bus stays stable across stalls.
  always_comb begin
    sif.mem_req_ready = (state_q == IDLE) && !reset;
    sif.busy          = (state_q != IDLE);
    sif.mem_rsp_valid = (state_q == RESP);
    sif.mem_rsp_data  = '0;
    sif.mem_rsp_tag   = '0;
    sif.bus_addr      = '0;
    sif.bus_ren       = 1'b0;
    sif.bus_wen       = 1'b0;
    sif.bus_wdata     = '0;
    sif.bus_strobe    = 4'h0;
    if (state_q == RESP) begin
      for (int w = 0; w < WORDS; w++) sif.mem_rsp_data[32*w +: 32] = line_q[w];
      sif.mem_rsp_tag = tag_q;
    end
    if (state_q == ACCESS) begin
      sif.bus_addr = word_addr(BASE_ADDR, 32'(addr_q), 32'(idx_q));
      if (!rw_q) begin
        sif.bus_ren    = 1'b1;
        sif.bus_strobe = 4'hF;
      end else if (cur_be != 4'h0) begin
        sif.bus_wen    = 1'b1;
        sif.bus_wdata  = line_q[idx_q];
        sif.bus_strobe = cur_be;
      end
    end
  end

endmodule

// File: tb/tb_vx_mem_line_serializer.sv
// Directed self-checking bench for vx_mem_line_serializer: reset, read, full and
// sparse writes, bus stall, response backpressure and reset during an access.
module tb_vx_mem_line_serializer;
  import vx_mem_serializer_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vx_mem_line_serializer_if sif ();

  // Zero-wait bus target that returns the word address as read data.
  assign sif.bus_rdata = sif.bus_addr;

  vx_mem_line_serializer dut (
    .clk  (clk),
    .reset(reset),
    .sif  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    sif.mem_req_valid  = 1'b0;
    sif.mem_req_rw     = 1'b0;
    sif.mem_req_byteen = '0;
    sif.mem_req_addr   = '0;
    sif.mem_req_data   = '0;
    sif.mem_req_tag    = '0;
  endtask

  // Presents a request at a negedge in IDLE; returns at the negedge of cycle T+1.
  task automatic issue(input logic rw, input logic [25:0] a, input logic [7:0] t,
                       input logic [63:0] be, input logic [511:0] d);
    sif.mem_req_valid  = 1'b1;
    sif.mem_req_rw     = rw;
    sif.mem_req_addr   = a;
    sif.mem_req_tag    = t;
    sif.mem_req_byteen = be;
    sif.mem_req_data   = d;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sif.mem_rsp_ready     = 1'b0;
    sif.bus_request_stall = 1'b0;
    drive_idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (sif.mem_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready c%0d: got %b expected 0", c, sif.mem_req_ready); end
      checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy c%0d: got %b expected 0", c, sif.busy); end
      checks++; if (sif.bus_ren !== 1'b0 || sif.bus_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes c%0d: got ren=%b wen=%b expected 0/0", c, sif.bus_ren, sif.bus_wen); end
      checks++; if (sif.bus_addr !== 32'h0 || sif.mem_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_rsp c%0d: got addr=%h rsp_valid=%b expected 0/0", c, sif.bus_addr, sif.mem_rsp_valid); end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (sif.mem_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", sif.mem_req_ready); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", sif.busy); end
  endtask

  task automatic test_read();
    logic [511:0] exp_line;
    logic [31:0]  exp_addr;
    sif.mem_rsp_ready = 1'b1;
    checks++; if (sif.mem_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL read_ready_before: got %b expected 1", sif.mem_req_ready); end
    issue(1'b0, 26'h10, 8'h05, 64'hFFFF_0000_0000_00FF, 512'h0);
    for (int i = 0; i < 16; i++) begin
      exp_addr = 32'h8000_0400 + 32'(4 * i);
      exp_line[32*i +: 32] = exp_addr;
      checks++; if (sif.bus_ren !== 1'b1 || sif.bus_wen !== 1'b0) begin errors++; $display("[TB] FAIL read_strobes[%0d]: got ren=%b wen=%b expected 1/0", i, sif.bus_ren, sif.bus_wen); end
      checks++; if (sif.bus_addr !== exp_addr) begin errors++; $display("[TB] FAIL read_addr[%0d]: got %h expected %h", i, sif.bus_addr, exp_addr); end
      checks++; if (sif.bus_strobe !== 4'hF) begin errors++; $display("[TB] FAIL read_strobe[%0d]: got %h expected F", i, sif.bus_strobe); end
      checks++; if (sif.mem_rsp_valid !== 1'b0 || sif.busy !== 1'b1) begin errors++; $display("[TB] FAIL read_early_rsp[%0d]: got rsp_valid=%b busy=%b expected 0/1", i, sif.mem_rsp_valid, sif.busy); end
      @(negedge clk);
    end
    checks++; if (sif.mem_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL read_rsp_valid: got %b expected 1", sif.mem_rsp_valid); end
    checks++; if (sif.mem_rsp_tag !== 8'h05) begin errors++; $display("[TB] FAIL read_rsp_tag: got %h expected 05", sif.mem_rsp_tag); end
    checks++; if (sif.mem_rsp_data !== exp_line) begin errors++; $display("[TB] FAIL read_rsp_data: got %h expected %h", sif.mem_rsp_data, exp_line); end
    @(negedge clk);
    checks++; if (sif.mem_rsp_valid !== 1'b0 || sif.mem_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL read_rsp_leave: got rsp_valid=%b ready=%b expected 0/1", sif.mem_rsp_valid, sif.mem_req_ready); end
  endtask

  task automatic test_write_full();
    logic [511:0] d;
    logic [31:0]  exp_addr;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = 32'hA5A5_0000 + 32'(w);
    sif.mem_rsp_ready = 1'b1;
    issue(1'b1, 26'h10, 8'h33, '1, d);
    for (int i = 0; i < 16; i++) begin
      exp_addr = 32'h8000_0400 + 32'(4 * i);
      checks++; if (sif.bus_wen !== 1'b1 || sif.bus_ren !== 1'b0) begin errors++; $display("[TB] FAIL wr_strobes[%0d]: got wen=%b ren=%b expected 1/0", i, sif.bus_wen, sif.bus_ren); end
      checks++; if (sif.bus_addr !== exp_addr) begin errors++; $display("[TB] FAIL wr_addr[%0d]: got %h expected %h", i, sif.bus_addr, exp_addr); end
      checks++; if (sif.bus_wdata !== 32'hA5A5_0000 + 32'(i)) begin errors++; $display("[TB] FAIL wr_wdata[%0d]: got %h expected %h", i, sif.bus_wdata, 32'hA5A5_0000 + 32'(i)); end
      checks++; if (sif.bus_strobe !== 4'hF) begin errors++; $display("[TB] FAIL wr_strobe[%0d]: got %h expected F", i, sif.bus_strobe); end
      checks++; if (sif.mem_rsp_valid !== 1'b0 || sif.mem_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_rsp_ready[%0d]: got rsp_valid=%b ready=%b expected 0/0", i, sif.mem_rsp_valid, sif.mem_req_ready); end
      @(negedge clk);
    end
    checks++; if (sif.mem_req_ready !== 1'b1 || sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_done: got ready=%b busy=%b expected 1/0", sif.mem_req_ready, sif.busy); end
    checks++; if (sif.mem_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_rsp: got %b expected 0", sif.mem_rsp_valid); end
  endtask

  task automatic test_sparse_write();
    logic [511:0] d;
    logic         exp_wen;
    int           wen_count = 0;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = 32'h1111_0000 + 32'(w);
    issue(1'b1, 26'h10, 8'h44, 64'h3000, d);
    for (int i = 0; i < 16; i++) begin
      exp_wen = (i == 3);
      if (sif.bus_wen === 1'b1) wen_count++;
      checks++; if (sif.bus_wen !== exp_wen || sif.bus_ren !== 1'b0) begin errors++; $display("[TB] FAIL sparse_wen[%0d]: got wen=%b ren=%b expected %b/0", i, sif.bus_wen, sif.bus_ren, exp_wen); end
      if (i == 3) begin
        checks++; if (sif.bus_addr !== 32'h8000_040C) begin errors++; $display("[TB] FAIL sparse_addr: got %h expected 8000040c", sif.bus_addr); end
        checks++; if (sif.bus_strobe !== 4'b0011) begin errors++; $display("[TB] FAIL sparse_strobe: got %b expected 0011", sif.bus_strobe); end
        checks++; if (sif.bus_wdata !== 32'h1111_0003) begin errors++; $display("[TB] FAIL sparse_wdata: got %h expected 11110003", sif.bus_wdata); end
      end
      @(negedge clk);
    end
    checks++; if (wen_count != 1) begin errors++; $display("[TB] FAIL sparse_wen_count: got %0d expected 1", wen_count); end
    checks++; if (sif.mem_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL sparse_ready: got %b expected 1", sif.mem_req_ready); end
  endtask

  task automatic test_stall();
    logic [511:0] exp_line;
    logic [31:0]  exp_addr;
    for (int w = 0; w < 16; w++) exp_line[32*w +: 32] = 32'h8000_0400 + 32'(4 * w);
    sif.mem_rsp_ready = 1'b1;
    issue(1'b0, 26'h10, 8'h22, 64'h0, 512'h0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (sif.bus_addr !== 32'h8000_0400 || sif.bus_ren !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got addr=%h ren=%b expected 80000400/1", c, sif.bus_addr, sif.bus_ren); end
      sif.bus_request_stall = (c < 3);
      @(negedge clk);
    end
    for (int i = 1; i < 16; i++) begin
      exp_addr = 32'h8000_0400 + 32'(4 * i);
      checks++; if (sif.bus_addr !== exp_addr || sif.mem_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_addr[%0d]: got addr=%h rsp_valid=%b expected %h/0", i, sif.bus_addr, sif.mem_rsp_valid, exp_addr); end
      @(negedge clk);
    end
    checks++; if (sif.mem_rsp_valid !== 1'b1 || sif.mem_rsp_tag !== 8'h22) begin errors++; $display("[TB] FAIL stall_rsp: got valid=%b tag=%h expected 1/22", sif.mem_rsp_valid, sif.mem_rsp_tag); end
    checks++; if (sif.mem_rsp_data !== exp_line) begin errors++; $display("[TB] FAIL stall_rsp_data: got %h expected %h", sif.mem_rsp_data, exp_line); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [511:0] exp_line;
    logic [31:0]  exp_addr;
    sif.mem_rsp_ready = 1'b0;
    issue(1'b0, 26'h3FF_FFFF, 8'hA7, 64'h0, 512'h0);
    for (int i = 0; i < 16; i++) begin
      exp_addr = 32'h7FFF_FFC0 + 32'(4 * i);
      exp_line[32*i +: 32] = exp_addr;
      checks++; if (sif.bus_addr !== exp_addr) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", i, sif.bus_addr, exp_addr); end
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      checks++; if (sif.mem_rsp_valid !== 1'b1 || sif.mem_rsp_tag !== 8'hA7) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b tag=%h expected 1/a7", k, sif.mem_rsp_valid, sif.mem_rsp_tag); end
      checks++; if (sif.mem_rsp_data !== exp_line) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", k, sif.mem_rsp_data, exp_line); end
      checks++; if (sif.mem_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", k, sif.mem_req_ready); end
      if (k == 0) begin
        sif.mem_req_valid  = 1'b1;
        sif.mem_req_rw     = 1'b1;
        sif.mem_req_byteen = '1;
        sif.mem_req_addr   = 26'h20;
      end
      @(negedge clk);
    end
    drive_idle();
    sif.mem_rsp_ready = 1'b1;
    checks++; if (sif.mem_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_still_valid: got %b expected 1", sif.mem_rsp_valid); end
    @(negedge clk);
    checks++; if (sif.mem_rsp_valid !== 1'b0 || sif.busy !== 1'b0 || sif.mem_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got valid=%b busy=%b ready=%b expected 0/0/1", sif.mem_rsp_valid, sif.busy, sif.mem_req_ready); end
  endtask

  task automatic test_reset_mid();
    sif.mem_rsp_ready = 1'b1;
    issue(1'b0, 26'h10, 8'h55, 64'h0, 512'h0);
    repeat (4) @(negedge clk);
    checks++; if (sif.busy !== 1'b1 || sif.bus_ren !== 1'b1) begin errors++; $display("[TB] FAIL mid_active: got busy=%b ren=%b expected 1/1", sif.busy, sif.bus_ren); end
    reset = 1'b1;
    #1;
    checks++; if (sif.mem_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready_in_reset: got %b expected 0", sif.mem_req_ready); end
    @(negedge clk);
    checks++; if (sif.busy !== 1'b0 || sif.bus_ren !== 1'b0 || sif.bus_wen !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle: got busy=%b ren=%b wen=%b expected 0/0/0", sif.busy, sif.bus_ren, sif.bus_wen); end
    checks++; if (sif.bus_addr !== 32'h0 || sif.mem_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_outputs: got addr=%h rsp_valid=%b expected 0/0", sif.bus_addr, sif.mem_rsp_valid); end
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++; if (sif.mem_rsp_valid !== 1'b0 || sif.busy !== 1'b0 || sif.mem_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_dropped[%0d]: got valid=%b busy=%b ready=%b expected 0/0/1", c, sif.mem_rsp_valid, sif.busy, sif.mem_req_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_full();
    test_sparse_write();
    test_stall();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
